fetch_controller: RTL and testbench

//  Sequences instruction fetch from the registered program ROM (enable/addr in, data_out 1 cycle later).

---
 rtl/fetch_controller_pkg.sv | 18 +
 rtl/fetch_controller_program_counter.sv | 38 +++
 rtl/fetch_controller.sv | 121 ++++++++++++
 tb/tb_fetch_controller.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the instruction fetch controller.
// Holds the FSM state encoding and the default geometry of the program ROM.
// No logic, so no latency or backpressure of its own.
package fetch_controller_pkg;

  localparam int ADDR_W_DEF   = 3;
  localparam int DATA_W_DEF   = 4;
  localparam int PROG_LEN_DEF = 7;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    CAPT = 3'd2,
    HOLD = 3'd3,
    HALT = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/fetch_controller_program_counter.sv
// Program counter: load, increment and optional wrap to 0 after the last ROM word.
// Latency: the new PC is visible the cycle after load/incr. Load takes priority over incr.
// Backpressure: none; the caller only pulses load/incr when a fetch is accepted.
// Ports: clock, reset (async, active-high), load + load_addr, incr, pc.
module program_counter
  import fetch_controller_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int PROG_LEN = PROG_LEN_DEF,
  parameter int WRAP     = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              incr,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PROG_LEN - 1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_addr;
    end else if (incr) begin
      // With wrapping, the word after the last valid address is address 0,
      // not PC+1, so PC never points beyond the program.
      if ((WRAP != 0) && (pc == LAST)) begin
        pc <= '0;
      end else begin
        pc <= pc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Fetch controller: sequences registered-ROM reads and hands each instruction to decode.
// Latency: start -> rom_enable next cycle -> instr_valid 3 cycles after start; 1 instr / 3 cycles max.
// Backpressure: instr/instr_pc held with instr_valid until instr_ready; no new ROM read while held.
// Ports: clock, reset (async, active-high), start, rom_enable/rom_addr/rom_data to the ROM,
//        instr/instr_pc/instr_valid/instr_ready to decode, jump_en/jump_addr, halted.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int PROG_LEN = PROG_LEN_DEF,
  parameter int WRAP     = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              rom_enable,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              halted
);

  // One extra bit so PROG_LEN == 2^ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   LEN  = (ADDR_W + 1)'(PROG_LEN);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PROG_LEN - 1);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              accept;
  logic              jump_ok;
  logic              at_last;
  logic              restart;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_addr;
  logic              pc_incr;

  assign accept  = (state == HOLD) && instr_ready;
  assign jump_ok = ({1'b0, jump_addr} < LEN);
  assign at_last = (pc == LAST);
  assign restart = ((state == IDLE) || (state == HALT)) && start;

  assign pc_load      = restart || (accept && jump_en && jump_ok);
  assign pc_load_addr = (accept && jump_en) ? jump_addr : '0;
  assign pc_incr      = accept && !jump_en && (!at_last || (WRAP != 0));

  // The ROM address is the PC itself; rom_enable qualifies it.
  assign rom_addr = pc;

  program_counter #(
    .ADDR_W  (ADDR_W),
    .PROG_LEN(PROG_LEN),
    .WRAP    (WRAP)
  ) u_pc (
    .clock    (clock),
    .reset    (reset),
    .load     (pc_load),
    .load_addr(pc_load_addr),
    .incr     (pc_incr),
    .pc       (pc)
  );

  // Outputs are registered alongside the state so each reflects the state
  // being entered; rom_enable is high only while in REQ.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rom_enable  <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            state      <= REQ;
            rom_enable <= 1'b1;
            halted     <= 1'b0;
          end
        end
        REQ: begin
          state      <= CAPT;
          rom_enable <= 1'b0;
        end
        CAPT: begin
          state       <= HOLD;
          instr       <= rom_data;
          instr_pc    <= pc;
          instr_valid <= 1'b1;
        end
        HOLD: begin
          if (accept) begin
            instr_valid <= 1'b0;
            // An out-of-range jump or running off the end without wrap stops
            // fetching rather than reading past the program.
            if (jump_en ? jump_ok : (!at_last || (WRAP != 0))) begin
              state      <= REQ;
              rom_enable <= 1'b1;
            end else begin
              state  <= HALT;
              halted <= 1'b1;
            end
          end
        end
        default: begin
          state       <= IDLE;
          rom_enable  <= 1'b0;
          instr_valid <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       instr_ready = 1'b0;
  logic       jump_en = 1'b0;
  logic [2:0] jump_addr = 3'd0;
  logic       rom_enable;
  logic [2:0] rom_addr;
  logic [3:0] rom_data = 4'd0;
  logic [3:0] instr;
  logic [2:0] instr_pc;
  logic       instr_valid;
  logic       halted;

  // Second controller, built with WRAP=1.
  logic       start2 = 1'b0;
  logic       ready2 = 1'b0;
  logic       rom_enable2;
  logic [2:0] rom_addr2;
  logic [3:0] rom_data2 = 4'd0;
  logic [3:0] instr2;
  logic [2:0] instr_pc2;
  logic       instr_valid2;
  logic       halted2;

  logic [3:0] rom [0:7];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  initial begin
    rom[0] = 4'd3; rom[1] = 4'd2; rom[2] = 4'd7; rom[3] = 4'd6;
    rom[4] = 4'd5; rom[5] = 4'd4; rom[6] = 4'd3; rom[7] = 4'd0;
  end

  // Registered ROM models: data_out updates only on an enabled read.
  always @(posedge clock) begin
    if (rom_enable)  rom_data  <= rom[rom_addr];
    if (rom_enable2) rom_data2 <= rom[rom_addr2];
  end

  fetch_controller #(.ADDR_W(3), .DATA_W(4), .PROG_LEN(7), .WRAP(0)) dut (
    .clock(clock), .reset(reset), .start(start),
    .rom_enable(rom_enable), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .jump_en(jump_en), .jump_addr(jump_addr),
    .halted(halted)
  );

  fetch_controller #(.ADDR_W(3), .DATA_W(4), .PROG_LEN(7), .WRAP(1)) dut_wrap (
    .clock(clock), .reset(reset), .start(start2),
    .rom_enable(rom_enable2), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .instr(instr2), .instr_pc(instr_pc2), .instr_valid(instr_valid2),
    .instr_ready(ready2), .jump_en(1'b0), .jump_addr(3'd0),
    .halted(halted2)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Start from IDLE/HALT and land in HOLD with the pc-0 word.
  task automatic go_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
  endtask

  // Accept the held instruction for one cycle and land in HOLD with the next one.
  task automatic step_accept(input logic jmp, input logic [2:0] addr);
    instr_ready = 1'b1; jump_en = jmp; jump_addr = addr;
    tick();
    instr_ready = 1'b0; jump_en = 1'b0; jump_addr = 3'd0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    n_cmp++;
    if ({rom_enable, rom_addr, instr, instr_pc, instr_valid, halted} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0",
               {rom_enable, rom_addr, instr, instr_pc, instr_valid, halted});
    end
    tick();
    reset = 1'b0;
    tick();
    n_cmp++;
    if ({rom_enable, instr_valid, halted} !== 3'b000) begin
      n_err++;
      $display("FAIL idle_no_start: got %b want 000", {rom_enable, instr_valid, halted});
    end
  endtask

  task automatic test_sequence();
    instr_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({rom_enable, rom_addr, instr_valid} !== {1'b1, 3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL req_cycle: got en=%b addr=%0d vld=%b want en=1 addr=0 vld=0",
               rom_enable, rom_addr, instr_valid);
    end
    instr_ready = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if ({instr_valid, instr, instr_pc, rom_enable, halted} !== {1'b1, rom[i], i[2:0], 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL seq_%0d: got vld=%b instr=%0d pc=%0d en=%b halt=%b want vld=1 instr=%0d pc=%0d en=0 halt=0",
                 i, instr_valid, instr, instr_pc, rom_enable, halted, rom[i], i);
      end
      if (i < 6) begin
        tick(); tick(); tick();
      end
    end
    tick();
    instr_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if ({halted, instr_valid, rom_enable} !== 3'b100) begin
        n_err++;
        $display("FAIL halt_after_last_%0d: got halt/vld/en=%b want 100", c,
                 {halted, instr_valid, rom_enable});
      end
      tick();
    end
  endtask

  task automatic test_stall();
    go_start();
    step_accept(1'b0, 3'd0);
    step_accept(1'b0, 3'd0);
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if ({instr_valid, instr, instr_pc, rom_enable} !== {1'b1, 4'd7, 3'd2, 1'b0}) begin
        n_err++;
        $display("FAIL stall_%0d: got vld=%b instr=%0d pc=%0d en=%b want vld=1 instr=7 pc=2 en=0",
                 c, instr_valid, instr, instr_pc, rom_enable);
      end
      tick();
    end
  endtask

  task automatic test_jump();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    go_start();
    step_accept(1'b0, 3'd0);
    n_cmp++;
    if ({instr, instr_pc} !== {4'd2, 3'd1}) begin
      n_err++;
      $display("FAIL pre_jump: got instr=%0d pc=%0d want instr=2 pc=1", instr, instr_pc);
    end
    step_accept(1'b1, 3'd5);
    n_cmp++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, 4'd4, 3'd5}) begin
      n_err++;
      $display("FAIL jump_to_5: got vld=%b instr=%0d pc=%0d want vld=1 instr=4 pc=5",
               instr_valid, instr, instr_pc);
    end
    // Jump request without accept must be ignored.
    jump_en = 1'b1; jump_addr = 3'd3;
    tick(); tick();
    jump_en = 1'b0; jump_addr = 3'd0;
    n_cmp++;
    if ({instr_valid, instr, instr_pc, rom_enable} !== {1'b1, 4'd4, 3'd5, 1'b0}) begin
      n_err++;
      $display("FAIL jump_no_accept: got vld=%b instr=%0d pc=%0d en=%b want vld=1 instr=4 pc=5 en=0",
               instr_valid, instr, instr_pc, rom_enable);
    end
    step_accept(1'b0, 3'd0);
    n_cmp++;
    if ({instr, instr_pc} !== {4'd3, 3'd6}) begin
      n_err++;
      $display("FAIL after_jump_inc: got instr=%0d pc=%0d want instr=3 pc=6", instr, instr_pc);
    end
  endtask

  task automatic test_jump_halt();
    instr_ready = 1'b1; jump_en = 1'b1; jump_addr = 3'd7;
    tick();
    instr_ready = 1'b0; jump_en = 1'b0; jump_addr = 3'd0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if ({halted, instr_valid, rom_enable} !== 3'b100) begin
        n_err++;
        $display("FAIL jump_oob_halt_%0d: got halt/vld/en=%b want 100", c,
                 {halted, instr_valid, rom_enable});
      end
      tick();
    end
    go_start();
    n_cmp++;
    if ({halted, instr_valid, instr, instr_pc} !== {1'b0, 1'b1, 4'd3, 3'd0}) begin
      n_err++;
      $display("FAIL restart_from_halt: got halt=%b vld=%b instr=%0d pc=%0d want halt=0 vld=1 instr=3 pc=0",
               halted, instr_valid, instr, instr_pc);
    end
  endtask

  task automatic test_reset_mid();
    step_accept(1'b0, 3'd0);
    n_cmp++;
    if ({instr_valid, rom_addr} !== {1'b1, 3'd1}) begin
      n_err++;
      $display("FAIL pre_reset_hold: got vld=%b addr=%0d want vld=1 addr=1", instr_valid, rom_addr);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({rom_enable, rom_addr, instr, instr_pc, instr_valid, halted} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_mid_hold: got %h want 0",
               {rom_enable, rom_addr, instr, instr_pc, instr_valid, halted});
    end
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    n_cmp++;
    if ({rom_enable, instr_valid, halted} !== 3'b000) begin
      n_err++;
      $display("FAIL after_reset_idle: got %b want 000", {rom_enable, instr_valid, halted});
    end
  endtask

  task automatic test_wrap();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    ready2 = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if ({instr_valid2, instr2, instr_pc2, halted2} !== {1'b1, rom[i % 7], 3'(i % 7), 1'b0}) begin
        n_err++;
        $display("FAIL wrap_%0d: got vld=%b instr=%0d pc=%0d halt=%b want vld=1 instr=%0d pc=%0d halt=0",
                 i, instr_valid2, instr2, instr_pc2, halted2, rom[i % 7], i % 7);
      end
      tick(); tick(); tick();
    end
    ready2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_stall();
    test_jump();
    test_jump_halt();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
